uart_rx_deserializer: RTL and testbench
=======================================

# uart_rx_deserializer

Receive-side counterpart of the UART transmit serializer. Oversamples the serial line, detects and qualifies the start bit, reassembles data bits LSB-first into a parallel byte, checks optional parity and the stop bit, and presents the byte with a one-cycle valid strobe. It sits between the RX pin (already synchronized upstream) and the byte consumer (register file / command FSM).

## Interface
- `DATA_WIDTH`, 8: data bits per frame.
- `PRESCALE`, 8: clock cycles per bit; legal values 8, 16, 32.
- `clk`  in  1  system clock; all logic on rising edge.
- `rst`  in  1  asynchronous, active-low reset.
- `RX_IN`  in  1  serial line, idle high, pre-synchronized.
- `PAR_EN`  in  1  1 = frame carries a parity bit.
- `PAR_TYP`  in  1  0 = even, 1 = odd parity.
- `P_DATA`  out  DATA_WIDTH  received byte, held until next good frame.
- `data_valid`  out  1  one-cycle strobe, P_DATA updated and good.
- `par_err`  out  1  one-cycle strobe, parity mismatch.
- `stp_err`  out  1  one-cycle strobe, stop bit sampled 0.

## Operation
- States: IDLE, START, DATA, PARITY, STOP.
- Edge counter `edge_cnt` (log2(PRESCALE) bits) runs 0..PRESCALE-1 per bit, wraps to 0; bit counter `bit_cnt` counts data bits 0..DATA_WIDTH-1.
- Bit value = majority of RX_IN at edge_cnt = P/2-1, P/2, P/2+1 (P = PRESCALE); decision taken on the edge ending edge_cnt = P/2+1.
- IDLE: RX_IN = 0 → START, edge_cnt = 0 in that cycle; PAR_EN/PAR_TYP latched; mid-frame changes ignored.
- START: decided bit 1 → glitch, back to IDLE, no strobes. Decided 0 → continue; at wrap → DATA.
- DATA: each decision shifts into shift register at MSB, shifting right (first bit received ends at bit 0). After DATA_WIDTH decisions and wrap → PARITY if PAR_EN latched, else STOP.
- PARITY: expected = XOR(data) for even, ~XOR(data) for odd; mismatch recorded into sticky frame flag; at wrap → STOP.
- STOP: on decision, go directly to IDLE (no wait for end of stop bit) and register results:
  - stop = 1, no parity error: P_DATA ← shift register, data_valid = 1.
  - parity error: par_err = 1, P_DATA unchanged.
  - stop = 0: stp_err = 1, P_DATA unchanged (both errors may assert together).
- Strobes are registered, high exactly one cycle, never high together with data_valid.
- Line held low after a stop error: IDLE sees RX_IN = 0 and starts a new frame (break not specially handled).

## Timing
- Reset (async, any state): state IDLE, counters 0, shift register 0, P_DATA = 0, data_valid = par_err = stp_err = 0. Reset mid-frame discards the frame silently.
- Latency, cycle 0 = first cycle RX_IN = 0 seen in IDLE: strobe high in cycle N·P + P/2 + 2, N = DATA_WIDTH + 1 (+1 if parity). P=8, 8 data bits: no parity cycle 78, parity cycle 86.
- START glitch rejected at cycle P/2+1; IDLE again from cycle P/2+2.
- Back-to-back frames: next start bit may begin immediately after stop bit; receiver is in IDLE from cycle N·P + P/2 + 2, before the next falling edge.
- Tolerance: majority window centred at mid-bit; sender rate error up to ±(P/2-2)/(P·(N+1)) of the bit period is accepted.

## Test plan
- No parity, P=8, send 0xA5 (bits 1,0,1,0,0,1,0,1 LSB-first) → P_DATA = 0xA5, data_valid high exactly cycle 78, no errors.
- PAR_EN=1 even, send 0x3C with parity 0 → data_valid cycle 86, P_DATA = 0x3C; repeat with parity 1 → par_err cycle 86, P_DATA keeps 0x3C from before, no data_valid.
- Send 0x55 with stop bit 0 → stp_err one cycle, data_valid 0, P_DATA unchanged; subsequent good 0x12 received normally.
- Glitch: RX_IN low 2 cycles then high → no strobes, state IDLE by cycle 6; following frame 0x81 received correctly.
- Back-to-back 0x01, 0xFE, 0x7E with zero idle gap → three data_valid strobes, correct bytes in order.
- Assert rst during DATA of frame 0xC3, release, send 0x42 → outputs 0 during reset, no strobe for aborted frame, 0x42 received.

Source files
------------

// File: rtl/uart_rx_deserializer.sv
// UART receiver: oversampled start-bit qualification, LSB-first data reassembly,
// optional even/odd parity and stop-bit checking with one-cycle result strobes.
module uart_rx_deserializer #(
  parameter int DATA_WIDTH = 8,
  parameter int PRESCALE   = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  RX_IN,
  input  logic                  PAR_EN,
  input  logic                  PAR_TYP,
  output logic [DATA_WIDTH-1:0] P_DATA,
  output logic                  data_valid,
  output logic                  par_err,
  output logic                  stp_err
);

  localparam int CW = $clog2(PRESCALE);
  localparam int BW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam logic [CW-1:0] MID_LO   = CW'(PRESCALE / 2 - 1);
  localparam logic [CW-1:0] MID      = CW'(PRESCALE / 2);
  localparam logic [CW-1:0] MID_HI   = CW'(PRESCALE / 2 + 1);
  localparam logic [CW-1:0] EDGE_END = CW'(PRESCALE - 1);
  localparam logic [BW-1:0] BIT_END  = BW'(DATA_WIDTH - 1);

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

  state_t                state;
  logic [CW-1:0]         edge_cnt;
  logic [BW-1:0]         bit_cnt;
  logic [DATA_WIDTH-1:0] shift_reg;
  logic                  samp0;
  logic                  samp1;
  logic                  par_en_lat;
  logic                  par_typ_lat;
  logic                  par_flag;
  logic                  bit_val;
  logic                  decide;
  logic                  wrap;

  // The third vote is the live line value, so the decision lands on the P/2+1 edge.
  assign bit_val = (samp0 & samp1) | (samp0 & RX_IN) | (samp1 & RX_IN);
  assign decide  = (edge_cnt == MID_HI);
  assign wrap    = (edge_cnt == EDGE_END);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= IDLE;
      edge_cnt    <= '0;
      bit_cnt     <= '0;
      shift_reg   <= '0;
      samp0       <= 1'b1;
      samp1       <= 1'b1;
      par_en_lat  <= 1'b0;
      par_typ_lat <= 1'b0;
      par_flag    <= 1'b0;
      P_DATA      <= '0;
      data_valid  <= 1'b0;
      par_err     <= 1'b0;
      stp_err     <= 1'b0;
    end else begin
      data_valid <= 1'b0;
      par_err    <= 1'b0;
      stp_err    <= 1'b0;
      if (edge_cnt == MID_LO) samp0 <= RX_IN;
      if (edge_cnt == MID)    samp1 <= RX_IN;
      if (state != IDLE) edge_cnt <= wrap ? '0 : edge_cnt + 1'b1;

      case (state)
        IDLE: begin
          // The cycle the falling edge is seen already counts as edge 0 of the start bit.
          if (!RX_IN) begin
            state       <= START;
            edge_cnt    <= CW'(1);
            bit_cnt     <= '0;
            par_flag    <= 1'b0;
            par_en_lat  <= PAR_EN;
            par_typ_lat <= PAR_TYP;
          end
        end
        START: begin
          if (decide && bit_val) begin
            state    <= IDLE;
            edge_cnt <= '0;
          end else if (wrap) begin
            state <= DATA;
          end
        end
        DATA: begin
          if (decide) shift_reg <= {bit_val, shift_reg[DATA_WIDTH-1:1]};
          if (wrap) begin
            if (bit_cnt == BIT_END) begin
              bit_cnt <= '0;
              state   <= par_en_lat ? PARITY : STOP;
            end else begin
              bit_cnt <= bit_cnt + 1'b1;
            end
          end
        end
        PARITY: begin
          if (decide) par_flag <= bit_val ^ (^shift_reg) ^ par_typ_lat;
          if (wrap) state <= STOP;
        end
        STOP: begin
          // Return to IDLE mid stop bit so a back-to-back start edge is never missed.
          if (decide) begin
            state    <= IDLE;
            edge_cnt <= '0;
            par_err  <= par_flag;
            stp_err  <= ~bit_val;
            if (bit_val && !par_flag) begin
              P_DATA     <= shift_reg;
              data_valid <= 1'b1;
            end
          end
        end
        default: begin
          state    <= IDLE;
          edge_cnt <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_rx_deserializer.sv
// Bench for uart_rx_deserializer: table of frames plus glitch and mid-frame reset
// sequences, with a scoreboard of expected strobes, their cycle and P_DATA.
module tb_uart_rx_deserializer;

  localparam int P  = 8;
  localparam int DW = 8;

  logic          clk = 1'b0;
  logic          rst;
  logic          RX_IN;
  logic          PAR_EN;
  logic          PAR_TYP;
  logic [DW-1:0] P_DATA;
  logic          data_valid;
  logic          par_err;
  logic          stp_err;

  int ncmp = 0;
  int nerr = 0;
  int cyc  = 0;
  logic [DW-1:0] last_good = '0;

  typedef struct {
    logic [2:0]    kind;
    logic [DW-1:0] data;
    int            cyc;
  } exp_t;
  exp_t scb[$];

  typedef struct {
    logic [DW-1:0] data;
    bit            par_en;
    bit            par_typ;
    bit            flip_par;
    bit            stop_bit;
    int            gap;
    logic [2:0]    exp_kind;
    int            exp_lat;
  } vec_t;

  uart_rx_deserializer #(.DATA_WIDTH(DW), .PRESCALE(P)) dut (
    .clk(clk), .rst(rst), .RX_IN(RX_IN), .PAR_EN(PAR_EN), .PAR_TYP(PAR_TYP),
    .P_DATA(P_DATA), .data_valid(data_valid), .par_err(par_err), .stp_err(stp_err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input int got, input int req);
    ncmp++;
    if (got != req) begin
      nerr++;
      $display("FAIL %s: got 0x%0h required 0x%0h", name, got, req);
    end
  endtask

  // Strobe kinds are {data_valid, par_err, stp_err}.
  always @(negedge clk) begin
    if (rst && (data_valid || par_err || stp_err)) begin
      if (scb.size() == 0) begin
        check("unexpected_strobe", int'({data_valid, par_err, stp_err}), 0);
      end else begin
        exp_t e;
        e = scb.pop_front();
        check("strobe_kind", int'({data_valid, par_err, stp_err}), int'(e.kind));
        check("strobe_cycle", cyc, e.cyc);
        if (e.kind == 3'b100) last_good = e.data;
        check("p_data", int'(P_DATA), int'(last_good));
      end
    end
  end

  task automatic send_bit(input logic b);
    RX_IN = b;
    repeat (P) @(negedge clk);
  endtask

  // Called on a negedge; cycle 0 of the frame is the cycle starting there.
  task automatic send_frame(input vec_t v);
    exp_t e;
    logic [DW-1:0] d;
    d      = v.data;
    e.kind = v.exp_kind;
    e.data = d;
    e.cyc  = cyc + v.exp_lat;
    scb.push_back(e);
    PAR_EN  = v.par_en;
    PAR_TYP = v.par_typ;
    send_bit(1'b0);
    for (int i = 0; i < DW; i++) send_bit(d[i]);
    if (v.par_en) send_bit((^d) ^ v.par_typ ^ v.flip_par);
    send_bit(v.stop_bit);
    RX_IN = 1'b1;
    repeat (v.gap) @(negedge clk);
  endtask

  vec_t vecs[10];
  vec_t hv;

  initial begin
    //        data   pe  pt  flip stop gap kind    lat
    vecs[0] = '{8'hA5, 0, 0, 0, 1, 4, 3'b100, 78};
    vecs[1] = '{8'h3C, 1, 0, 0, 1, 4, 3'b100, 86};
    vecs[2] = '{8'h3C, 1, 0, 1, 1, 4, 3'b010, 86};
    vecs[3] = '{8'h55, 0, 0, 0, 0, 8, 3'b001, 78};
    vecs[4] = '{8'h12, 0, 0, 0, 1, 4, 3'b100, 78};
    vecs[5] = '{8'h5A, 1, 1, 0, 1, 4, 3'b100, 86};
    vecs[6] = '{8'h5A, 1, 1, 1, 0, 8, 3'b011, 86};
    vecs[7] = '{8'h01, 0, 0, 0, 1, 0, 3'b100, 78};
    vecs[8] = '{8'hFE, 0, 0, 0, 1, 0, 3'b100, 78};
    vecs[9] = '{8'h7E, 0, 0, 0, 1, 4, 3'b100, 78};

    rst = 1'b0; RX_IN = 1'b1; PAR_EN = 1'b0; PAR_TYP = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_p_data", int'(P_DATA), 0);
    check("reset_data_valid", int'(data_valid), 0);
    check("reset_par_err", int'(par_err), 0);
    check("reset_stp_err", int'(stp_err), 0);
    rst = 1'b1;
    repeat (4) @(negedge clk);

    for (int i = 0; i < 10; i++) send_frame(vecs[i]);

    // Two-cycle glitch, then a real frame starting at cycle 6 of the glitch.
    RX_IN = 1'b0;
    repeat (2) @(negedge clk);
    RX_IN = 1'b1;
    repeat (4) @(negedge clk);
    hv = '{8'h81, 0, 0, 0, 1, 4, 3'b100, 78};
    send_frame(hv);
    check("queue_drained_before_reset", scb.size(), 0);

    // Abort frame 0xC3 during its data bits.
    send_bit(1'b0);
    send_bit(1'b1);
    send_bit(1'b1);
    RX_IN = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    #1;
    last_good = '0;
    check("midreset_p_data", int'(P_DATA), 0);
    check("midreset_strobes", int'({data_valid, par_err, stp_err}), 0);
    RX_IN = 1'b1;
    repeat (3) @(negedge clk);
    check("midreset_hold_p_data", int'(P_DATA), 0);
    rst = 1'b1;
    repeat (4) @(negedge clk);
    hv = '{8'h42, 0, 0, 0, 1, 4, 3'b100, 78};
    send_frame(hv);

    repeat (20) @(negedge clk);
    check("final_p_data", int'(P_DATA), 'h42);
    check("queue_drained_at_end", scb.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout required completion");
    $fatal(1, "watchdog expired");
  end

endmodule
